// File: rtl/syst_collect_if.sv
// Handshake bundle between the systolic result lanes, the collector and the downstream row consumer.
interface syst_collect_if #(
  parameter int N     = 3,
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_diag;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] out_row;
  logic               out_last;

  modport master (
    output in_valid, in_diag, out_ready,
    input  in_ready, out_valid, out_row, out_last
  );

  modport slave (
    input  in_valid, in_diag, out_ready,
    output in_ready, out_valid, out_row, out_last
  );
endinterface

// File: rtl/syst_collect.sv
// Collects skewed anti-diagonal wavefronts into a ping-pong NxN buffer and
// streams each completed matrix out row-major.
module syst_collect #(
  parameter int N     = 3,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  syst_collect_if.slave  bus
);
  localparam int KW = (N > 1) ? $clog2(2*N-1) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(2*N-2);
  localparam logic [RW-1:0] R_LAST = RW'(N-1);

  logic [KW-1:0]    k_r, k_nxt_s;
  logic [RW-1:0]    r_r, r_nxt_s;
  logic             wbank_r, wbank_nxt_s;
  logic             rbank_r, rbank_nxt_s;
  logic [1:0]       full_r, full_nxt_s;
  logic [WIDTH-1:0] bank_r [0:1][0:N-1][0:N-1];

  logic             wr_fire_s, rd_fire_s;
  logic             wr_done_s, rd_done_s;
  logic [N*WIDTH-1:0] out_row_s;

  // Handshake decode and next-state for counters, bank selects and full flags.
  always_comb begin
    wr_fire_s   = bus.in_valid && !full_r[wbank_r];
    rd_fire_s   = full_r[rbank_r] && bus.out_ready;
    wr_done_s   = wr_fire_s && (k_r == K_LAST);
    rd_done_s   = rd_fire_s && (r_r == R_LAST);
    k_nxt_s     = k_r;
    r_nxt_s     = r_r;
    wbank_nxt_s = wbank_r;
    rbank_nxt_s = rbank_r;
    full_nxt_s  = full_r;

    if (wr_done_s) begin
      k_nxt_s             = {KW{1'b0}};
      wbank_nxt_s         = ~wbank_r;
      full_nxt_s[wbank_r] = 1'b1;
    end else if (wr_fire_s) begin
      k_nxt_s = k_r + KW'(1);
    end else begin
      k_nxt_s = k_r;
    end

    // The bank being drained is never the bank being filled, so set and clear cannot collide.
    if (rd_done_s) begin
      r_nxt_s             = {RW{1'b0}};
      rbank_nxt_s         = ~rbank_r;
      full_nxt_s[rbank_r] = 1'b0;
    end else if (rd_fire_s) begin
      r_nxt_s = r_r + RW'(1);
    end else begin
      r_nxt_s = r_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_r     <= {KW{1'b0}};
      r_r     <= {RW{1'b0}};
      wbank_r <= 1'b0;
      rbank_r <= 1'b0;
      full_r  <= 2'b00;
    end else begin
      k_r     <= k_nxt_s;
      r_r     <= r_nxt_s;
      wbank_r <= wbank_nxt_s;
      rbank_r <= rbank_nxt_s;
      full_r  <= full_nxt_s;
    end
  end

  // Matrix storage: on wave k, lane i lands in column k-i; lanes outside the matrix are dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            bank_r[b][i][j] <= {WIDTH{1'b0}};
          end
        end
      end
    end else if (wr_fire_s) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (int'(k_r) == i + j) begin
            bank_r[wbank_r][i][j] <= bus.in_diag[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Row read mux; held stable by the row counter while the consumer stalls.
  always_comb begin
    out_row_s = {(N*WIDTH){1'b0}};
    for (int j = 0; j < N; j++) begin
      out_row_s[j*WIDTH +: WIDTH] = bank_r[rbank_r][r_r][j];
    end
  end

  assign bus.in_ready  = !full_r[wbank_r];
  assign bus.out_valid = full_r[rbank_r];
  assign bus.out_last  = full_r[rbank_r] && (r_r == R_LAST);
  assign bus.out_row   = out_row_s;
endmodule
